fetch_queue: RTL and testbench

- Next-generation instruction fetch stage for the LEGv8 core.
- Owns the PC, issues requests to a synchronous instruction memory and buffers fetched {pc, instruction} pairs in a DEPTH-entry FIFO.
- Hands entries to decode over a valid/ready handshake, so fetch keeps running while decode stalls.
- Accepts a single redirect (branch, register jump, flush) that squashes all younger work.

---
 rtl/fetch_queue_if.sv | 29 ++
 rtl/fetch_queue.sv | 113 +++++++++++
 tb/tb_fetch_queue.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory read bus plus decode handoff handshake.
// master = fetch side (drives imem_req/addr, out_*); slave = imem/decode side.
interface fetch_queue_if #(
  parameter int WORD_W  = 64,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [WORD_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [WORD_W-1:0]  out_pc;
  logic [WORD_W-1:0]  out_next_pc;
  logic [INSTR_W-1:0] out_instruction;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    output out_valid, out_pc, out_next_pc, out_instruction,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    input  out_valid, out_pc, out_next_pc, out_instruction,
    output out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner + sync imem requester + DEPTH-entry {pc,instr} FIFO.
// Ports: clk, reset (sync, high), redirect_valid/redirect_pc, bus (fetch_queue_if.master),
// occupancy; FETCH_QUEUE_PERF_EN adds perf_fetched/perf_squashed.
module fetch_queue #(
  parameter int               WORD_W   = 64,
  parameter int               INSTR_W  = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         redirect_valid,
  input  logic [WORD_W-1:0]            redirect_pc,
  fetch_queue_if.master                bus,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]                  perf_fetched,
  output logic [31:0]                  perf_squashed
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [WORD_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t             fifo_q [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [OW-1:0]      occ;
  logic [WORD_W-1:0]  fetch_pc;
  logic [WORD_W-1:0]  cap_pc;
  logic               inflight;
  logic [OW:0]        credit;
  logic               issue;
  logic               push;
  logic               pop;

  // Outstanding response reserves a slot; same-cycle pop is not credited.
  assign credit = {1'b0, occ} + (OW+1)'(inflight);
  assign issue  = !reset && !redirect_valid
               && (credit < (OW+1)'(DEPTH));
  assign push   = inflight;
  assign pop    = bus.out_valid && bus.out_ready;

  assign bus.imem_req        = issue;
  assign bus.imem_addr       = fetch_pc;
  assign bus.out_valid       = (occ != '0);
  assign bus.out_pc          = fifo_q[rd_ptr].pc;
  assign bus.out_next_pc     = fifo_q[rd_ptr].pc + WORD_W'(4);
  assign bus.out_instruction = fifo_q[rd_ptr].instr;
  assign occupancy           = occ;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      cap_pc   <= '0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
    end else if (redirect_valid) begin
      // Any response arriving now belongs to the old path: drop it.
      fetch_pc <= {redirect_pc[WORD_W-1:2], 2'b00};
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + WORD_W'(4);
        cap_pc   <= fetch_pc;
      end
      if (push) begin
        fifo_q[wr_ptr] <= '{pc: cap_pc, instr: bus.imem_rdata};
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      occ <= occ + OW'(push) - OW'(pop);
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [OW:0] drop;
  logic [32:0] sq_sum;

  // Entries left after the redirect-cycle pop, plus the dropped response.
  assign drop   = {1'b0, occ} - (OW+1)'(pop) + (OW+1)'(inflight);
  assign sq_sum = {1'b0, perf_squashed} + 33'(drop);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      if (pop && perf_fetched != '1) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (redirect_valid) begin
        perf_squashed <= sq_sum[32] ? '1 : sq_sum[31:0];
      end
    end
  end
`else
  // Performance counters not built.
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue streaming, backpressure,
// redirect, wrap and reset; memory model returns addr>>2.
module tb_fetch_queue;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic        rv_a, rv_b;
  logic [63:0] rpc_a, rpc_b;
  logic [2:0]  occ_a, occ_b;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] pf_a, ps_a, pf_b, ps_b;
  logic [31:0] ps_before, pf_before;
`endif

  fetch_queue_if bus_a ();
  fetch_queue_if bus_b ();

  fetch_queue #(.RESET_PC(64'h0)) dut_a (
    .clk            (clk),
    .reset          (rst_a),
    .redirect_valid (rv_a),
    .redirect_pc    (rpc_a),
    .bus            (bus_a),
    .occupancy      (occ_a)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .perf_fetched   (pf_a),
    .perf_squashed  (ps_a)
`endif
  );

  fetch_queue #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut_b (
    .clk            (clk),
    .reset          (rst_b),
    .redirect_valid (rv_b),
    .redirect_pc    (rpc_b),
    .bus            (bus_b),
    .occupancy      (occ_b)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .perf_fetched   (pf_b),
    .perf_squashed  (ps_b)
`endif
  );

  always @(posedge clk) begin
    if (bus_a.imem_req) bus_a.imem_rdata <= bus_a.imem_addr[33:2];
    if (bus_b.imem_req) bus_b.imem_rdata <= bus_b.imem_addr[33:2];
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    rv_a = 1'b0; rv_b = 1'b0;
    rpc_a = '0; rpc_b = '0;
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;
    tick(); tick();

    // reset state
    chk("rst_occ", 64'(occ_a), 0);
    chk("rst_valid", 64'(bus_a.out_valid), 0);
    chk("rst_req", 64'(bus_a.imem_req), 0);

    // streaming
    rst_a = 1'b0; #1;
    chk("s_req0", 64'(bus_a.imem_req), 1);
    chk("s_addr0", bus_a.imem_addr, 0);
    chk("s_valid0", 64'(bus_a.out_valid), 0);
    tick();
    chk("s_addr1", bus_a.imem_addr, 4);
    chk("s_valid1", 64'(bus_a.out_valid), 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("s_valid", 64'(bus_a.out_valid), 1);
      chk("s_pc", bus_a.out_pc, 64'(4*k));
      chk("s_npc", bus_a.out_next_pc, 64'(4*k+4));
      chk("s_ins", 64'(bus_a.out_instruction), 64'(k));
      chk("s_addr", bus_a.imem_addr, 64'(4*k+8));
      chk("s_occ", 64'(occ_a), 1);
      tick();
    end

    // redirect with a response in flight (c5 now)
    tick(); tick(); tick();
    chk("r_addr20", bus_a.imem_addr, 64'h20);
    tick();
    rv_a = 1'b1; rpc_a = 64'h103; #1;
    chk("r_req_blk", 64'(bus_a.imem_req), 0);
    chk("r_pop_pc", bus_a.out_pc, 64'h1C);
`ifdef FETCH_QUEUE_PERF_EN
    ps_before = ps_a;
`endif
    tick();
    rv_a = 1'b0; #1;
    chk("r_occ", 64'(occ_a), 0);
    chk("r_valid", 64'(bus_a.out_valid), 0);
    chk("r_req", 64'(bus_a.imem_req), 1);
    chk("r_addr", bus_a.imem_addr, 64'h100);
`ifdef FETCH_QUEUE_PERF_EN
    chk("r_perf_sq", 64'(ps_a - ps_before), 1);
`endif
    tick();
    chk("r_valid1", 64'(bus_a.out_valid), 0);
    chk("r_addr1", bus_a.imem_addr, 64'h104);
    tick();
    chk("r_valid2", 64'(bus_a.out_valid), 1);
    chk("r_pc", bus_a.out_pc, 64'h100);
    chk("r_npc", bus_a.out_next_pc, 64'h104);
    chk("r_ins", 64'(bus_a.out_instruction), 64'h40);

    // back-to-back redirects: last wins
    rv_a = 1'b1; rpc_a = 64'h200;
    tick();
    rpc_a = 64'h300;
    tick();
    rv_a = 1'b0; #1;
    chk("bb_addr", bus_a.imem_addr, 64'h300);
    tick();
    chk("bb_valid0", 64'(bus_a.out_valid), 0);
    tick();
    chk("bb_pc", bus_a.out_pc, 64'h300);
    chk("bb_valid", 64'(bus_a.out_valid), 1);

    // backpressure
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0; bus_a.out_ready = 1'b0;
    repeat (10) tick();
    chk("bp_occ", 64'(occ_a), 4);
    chk("bp_req", 64'(bus_a.imem_req), 0);
    chk("bp_fpc", bus_a.imem_addr, 16);
    chk("bp_head", bus_a.out_pc, 0);
    bus_a.out_ready = 1'b1; #1;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) chk("bp_req_d0", 64'(bus_a.imem_req), 0);
      if (i == 1) chk("bp_addr_d1", bus_a.imem_addr, 16);
      chk("bp_valid", 64'(bus_a.out_valid), 1);
      chk("bp_pc", bus_a.out_pc, 64'(4*i));
      tick();
    end

    // redirect while full, head pop in the same cycle
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0; bus_a.out_ready = 1'b0;
    repeat (10) tick();
    chk("f_occ", 64'(occ_a), 4);
`ifdef FETCH_QUEUE_PERF_EN
    ps_before = ps_a;
    pf_before = pf_a;
`endif
    bus_a.out_ready = 1'b1; rv_a = 1'b1; rpc_a = 64'h400; #1;
    chk("f_valid", 64'(bus_a.out_valid), 1);
    chk("f_head", bus_a.out_pc, 0);
    chk("f_req", 64'(bus_a.imem_req), 0);
    tick();
    rv_a = 1'b0; #1;
    chk("f_occ0", 64'(occ_a), 0);
    chk("f_valid0", 64'(bus_a.out_valid), 0);
    chk("f_addr", bus_a.imem_addr, 64'h400);
    chk("f_req1", 64'(bus_a.imem_req), 1);
`ifdef FETCH_QUEUE_PERF_EN
    chk("f_perf_sq", 64'(ps_a - ps_before), 3);
    chk("f_perf_pf", 64'(pf_a - pf_before), 1);
`endif
    tick(); tick();
    chk("f_pc", bus_a.out_pc, 64'h400);

    // reset mid-stream: 2 entries queued, one request in flight
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0; bus_a.out_ready = 1'b0;
    tick(); tick(); tick();
    chk("m_occ", 64'(occ_a), 2);
    rst_a = 1'b1; #1;
    chk("m_req_rst", 64'(bus_a.imem_req), 0);
    tick();
    chk("m_occ0", 64'(occ_a), 0);
    chk("m_valid", 64'(bus_a.out_valid), 0);
    chk("m_req", 64'(bus_a.imem_req), 0);
`ifdef FETCH_QUEUE_PERF_EN
    chk("m_pf", 64'(pf_a), 0);
    chk("m_ps", 64'(ps_a), 0);
`endif
    rst_a = 1'b0; #1;
    chk("m_req1", 64'(bus_a.imem_req), 1);
    chk("m_addr", bus_a.imem_addr, 0);
    tick();
    chk("m_occ1", 64'(occ_a), 0);

    // PC wrap
    rst_b = 1'b0; #1;
    chk("w_addr0", bus_b.imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("w_req", 64'(bus_b.imem_req), 1);
    tick();
    chk("w_addr1", bus_b.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("w_addr2", bus_b.imem_addr, 0);
    chk("w_pc0", bus_b.out_pc, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("w_npc0", bus_b.out_next_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("w_ins0", 64'(bus_b.out_instruction), 64'hFFFF_FFFE);
    tick();
    chk("w_pc1", bus_b.out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("w_npc1", bus_b.out_next_pc, 0);
    chk("w_ins1", 64'(bus_b.out_instruction), 64'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
